pwm_gen_n: RTL and testbench
============================

PWM_GEN_N -- requirements
Module: pwm_gen_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the counter, period and per-channel duty width in bits.
REQ-002 SHALL have parameter CH, default 3, giving the number of PWM channels (one per BLDC phase).
REQ-003 SHALL have parameter DEAD, default 2, giving the dead-time in CLK cycles (0 to 255).
REQ-004 SHALL have port CLK  input  1  system clock; all flops on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port E  input  1  enable; 1 = run, 0 = counter halted and all outputs off.
REQ-007 SHALL have port PERIOD  input  WIDTH  counter top value; period length is PERIOD+1 cycles.
REQ-008 SHALL have port D  input  CH*WIDTH  duty per channel; channel i is bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port LD  input  1  one-cycle strobe that captures PERIOD and D into the pending registers.
REQ-010 SHALL have port P_H  output  CH  high-side gate drive per channel, registered.
REQ-011 SHALL have port P_L  output  CH  low-side gate drive per channel, registered.
REQ-012 SHALL have port SYNC  output  1  period-start pulse, registered.

Function
REQ-013 SHALL implement counter CNT: while E=1, CNT increments by 1 each cycle; at CNT==per_act the next value is 0 (wrap).
REQ-014 SHALL hold CNT at 0 while E=0.
REQ-015 SHALL, on LD=1, capture PERIOD and all D into pending registers and set flag pend=1.
REQ-016 SHALL, at a wrap edge or at the first edge with E=1 after E=0, copy pending into active (per_act, duty_act[i]) and clear pend, provided pend=1.
REQ-017 SHALL, when LD=1 coincides with such an edge, load the values present on PERIOD and D into active directly and leave pend=0.
REQ-018 SHALL NOT update active registers at any other time; mid-period LD never changes the running waveform.
REQ-019 SHALL compute raw_i = (CNT < duty_act[i]) as an unsigned WIDTH-bit compare.
REQ-020 SHALL treat duty 0 as 0 % (raw always 0) and duty > per_act as 100 % (raw always 1).
REQ-021 SHALL keep a per-channel dead-time counter that counts consecutive cycles of unchanged raw_i, resets on each raw_i change, and saturates at DEAD.
REQ-022 SHALL register P_H[i]=1 only when raw_i=1 and the dead-time counter has reached DEAD; likewise P_L[i]=1 only when raw_i=0 and the counter has reached DEAD.
REQ-023 SHALL give output latency of DEAD+1 cycles from a raw_i edge to the asserting output edge, and 1 cycle from a raw_i edge to the deasserting output edge.
REQ-024 SHALL never assert P_H[i] and P_L[i] in the same cycle.
REQ-025 SHALL, with DEAD=0, make P_H = raw delayed by 1 cycle and P_L = its complement.
REQ-026 SHALL drive SYNC=1 for exactly the cycles in which CNT==0 while E=1; with PERIOD=0, SYNC stays at 1 continuously.
REQ-027 SHALL, while E=0, force P_H=0, P_L=0 and SYNC=0, and hold the dead-time counters at 0 so that the first output after enable waits DEAD cycles.
REQ-028 SHALL, when E falls mid-period, force outputs off at the next edge and restart from CNT=0 on re-enable.

Reset
REQ-029 SHALL asynchronously set, on RST=1: CNT=0, per_act all-ones, duty_act=0, pending=0, pend=0, dead-time counters=0, P_H=0, P_L=0, SYNC=0.
REQ-030 SHALL resume operation on the first rising CLK edge after RST falls; reset asserted mid-period discards pending and active values.

Verification
REQ-031 SHALL be verified with WIDTH=4, CH=1, DEAD=0, LD with PERIOD=15, D=14, E=1 -> P_H high 14 of every 16 cycles, P_L high 2, SYNC once per 16 cycles.
REQ-032 SHALL be verified with DEAD=2, PERIOD=9, D=5 -> P_H high 3 cycles per period, P_L high 3 cycles, each transition separated by 2 cycles with both outputs low.
REQ-033 SHALL be verified by applying LD with D=2 at CNT=4 while D=6 is active -> the current period keeps 6 high cycles and the next period has 2, with the change exactly at SYNC.
REQ-034 SHALL be verified for the boundaries D=0 -> P_H never 1; D=PERIOD+1 and D=all-ones -> P_L never 1; PERIOD=0 -> SYNC constant 1.
REQ-035 SHALL be verified with CH=3 and distinct duties 3/8/12 at PERIOD=15 -> each channel independent and all aligned to the same SYNC.
REQ-036 SHALL be verified by asserting RST for 1 cycle mid-period and E=0 for 5 cycles -> outputs 0 immediately, restart from CNT=0, and no P_H/P_L overlap at any time.

Source files
------------

// File: rtl/pwm_gen_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_gen_n : multi-channel edge-aligned PWM, double-buffered period/duty, dead-time
// Revision  : 1.0
// ---------------------------------------------------------------------------
module pwm_gen_n #(
  parameter int WIDTH = 8,
  parameter int CH    = 3,
  parameter int DEAD  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                E,
  input  logic [WIDTH-1:0]    PERIOD,
  input  logic [CH*WIDTH-1:0] D,
  input  logic                LD,
  output logic [CH-1:0]       P_H,
  output logic [CH-1:0]       P_L,
  output logic                SYNC
);

  localparam int            DW     = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
  localparam logic [DW-1:0] DEAD_V = DW'(DEAD);

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    per_act;
  logic [WIDTH-1:0]    per_pend;
  logic [CH*WIDTH-1:0] duty_act;
  logic [CH*WIDTH-1:0] duty_pend;
  logic                pend;
  logic                e_d;
  logic                wrap;
  logic                load_edge;
  logic [CH-1:0]       raw;
  logic [CH-1:0]       raw_d;
  logic [DW-1:0]       run     [CH];
  logic [DW-1:0]       run_nxt [CH];

  // >= rather than == so a period shortened on the first enabled edge still wraps
  assign wrap      = (cnt >= per_act);
  assign load_edge = E && (!e_d || wrap);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      per_act   <= '1;
      per_pend  <= '0;
      duty_act  <= '0;
      duty_pend <= '0;
      pend      <= 1'b0;
      e_d       <= 1'b0;
      SYNC      <= 1'b0;
    end else begin
      e_d  <= E;
      SYNC <= E && (cnt == '0);
      if (!E || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load_edge && LD) begin
        per_act  <= PERIOD;
        duty_act <= D;
        pend     <= 1'b0;
      end else if (load_edge && pend) begin
        per_act  <= per_pend;
        duty_act <= duty_pend;
        pend     <= 1'b0;
      end else if (LD) begin
        per_pend  <= PERIOD;
        duty_pend <= D;
        pend      <= 1'b1;
      end
    end
  end

  // run length of unchanged raw; the first enabled cycle always counts as a new edge
  always_comb begin
    raw = '0;
    for (int i = 0; i < CH; i++) begin
      run_nxt[i] = '0;
      raw[i]     = (cnt < duty_act[i*WIDTH +: WIDTH]);
      if (e_d && (raw[i] == raw_d[i])) begin
        run_nxt[i] = (run[i] == DEAD_V) ? run[i] : run[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      raw_d <= '0;
      P_H   <= '0;
      P_L   <= '0;
      for (int i = 0; i < CH; i++) begin
        run[i] <= '0;
      end
    end else begin
      raw_d <= raw;
      for (int i = 0; i < CH; i++) begin
        run[i] <= E ? run_nxt[i] : '0;
        P_H[i] <= E &&  raw[i] && (run_nxt[i] == DEAD_V);
        P_L[i] <= E && !raw[i] && (run_nxt[i] == DEAD_V);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pwm_gen_n : two DUT builds compared to a cycle model plus literal duty counts
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_pwm_gen_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        e0, ld0, sync0;
  logic [3:0]  per0, d0;
  logic [0:0]  ph0, pl0;
  logic        e1, ld1, sync1;
  logic [3:0]  per1;
  logic [11:0] d1;
  logic [2:0]  ph1, pl1;

  pwm_gen_n #(.WIDTH(4), .CH(1), .DEAD(0)) dut0 (
    .CLK(clk), .RST(rst), .E(e0), .PERIOD(per0), .D(d0), .LD(ld0),
    .P_H(ph0), .P_L(pl0), .SYNC(sync0));

  pwm_gen_n #(.WIDTH(4), .CH(3), .DEAD(2)) dut1 (
    .CLK(clk), .RST(rst), .E(e1), .PERIOD(per1), .D(d1), .LD(ld1),
    .P_H(ph1), .P_L(pl1), .SYNC(sync1));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: outputs follow from the rule "raw held, enabled, for DEAD+1 straight cycles"
  int          m_cnt [2];
  int          m_per [2];
  int          m_pper[2];
  int          m_duty [2][3];
  int          m_pduty[2][3];
  bit          m_pend [2];
  bit          m_eprev[2];
  int unsigned eh[2];
  int unsigned rh[2][3];
  logic [2:0]  x_ph[2];
  logic [2:0]  x_pl[2];
  logic        x_sync[2];

  function automatic int nch(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  function automatic int dead(input int j);
    return (j == 0) ? 0 : 2;
  endfunction

  task automatic model_reset(input int j);
    m_cnt[j] = 0;  m_per[j] = 15;  m_pper[j] = 0;
    m_pend[j] = 1'b0;  m_eprev[j] = 1'b0;  eh[j] = 0;
    for (int c = 0; c < 3; c++) begin
      m_duty[j][c] = 0;  m_pduty[j][c] = 0;  rh[j][c] = 0;
    end
    x_ph[j] = '0;  x_pl[j] = '0;  x_sync[j] = 1'b0;
  endtask

  task automatic model_step(input int j, input bit e, input int per, input int d, input bit ld);
    int unsigned mask;
    int          ncnt;
    bit          raw, load, armed;
    mask  = (1 << (dead(j) + 1)) - 1;
    eh[j] = (eh[j] << 1) | e;
    armed = ((eh[j] & mask) == mask);
    x_sync[j] = e && (m_cnt[j] == 0);
    x_ph[j] = '0;
    x_pl[j] = '0;
    for (int c = 0; c < nch(j); c++) begin
      raw = (m_cnt[j] < m_duty[j][c]);
      rh[j][c] = (rh[j][c] << 1) | raw;
      x_ph[j][c] = armed && ((rh[j][c] & mask) == mask);
      x_pl[j][c] = armed && ((rh[j][c] & mask) == 0);
    end
    load = e && (!m_eprev[j] || (m_cnt[j] >= m_per[j]));
    ncnt = (!e || (m_cnt[j] >= m_per[j])) ? 0 : m_cnt[j] + 1;
    if (load && ld) begin
      m_per[j] = per;
      for (int c = 0; c < 3; c++) m_duty[j][c] = (d >> (4 * c)) & 15;
      m_pend[j] = 1'b0;
    end else if (load && m_pend[j]) begin
      m_per[j] = m_pper[j];
      for (int c = 0; c < 3; c++) m_duty[j][c] = m_pduty[j][c];
      m_pend[j] = 1'b0;
    end else if (ld) begin
      m_pper[j] = per;
      for (int c = 0; c < 3; c++) m_pduty[j][c] = (d >> (4 * c)) & 15;
      m_pend[j] = 1'b1;
    end
    m_cnt[j]   = ncnt;
    m_eprev[j] = e;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end
    check("m_ph0",   ph0,   x_ph[0][0]);
    check("m_pl0",   pl0,   x_pl[0][0]);
    check("m_sync0", sync0, x_sync[0]);
    check("m_ph1",   ph1,   x_ph[1]);
    check("m_pl1",   pl1,   x_pl[1]);
    check("m_sync1", sync1, x_sync[1]);
    check("overlap0", ph0 & pl0, 0);
    check("overlap1", ph1 & pl1, 0);
    if (!rst) begin
      model_step(0, e0, per0, d0, ld0);
      model_step(1, e1, per1, d1, ld1);
    end
  end

  int cph[3], cpl[3], cboth[3], csync;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sync(input int j);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if ((j == 0) ? sync0 : sync1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_sync%0d: got no SYNC within 64 cycles, expected one", j);
    end
  endtask

  task automatic sample(input int j);
    logic [2:0] h, l;
    h = (j == 0) ? {2'b00, ph0} : ph1;
    l = (j == 0) ? {2'b00, pl0} : pl1;
    for (int c = 0; c < 3; c++) begin
      cph[c]   += h[c];
      cpl[c]   += l[c];
      cboth[c] += (!h[c] && !l[c]);
    end
    csync += (j == 0) ? sync0 : sync1;
  endtask

  // counts n consecutive cycles starting with the current one
  task automatic measure(input int j, input int n);
    for (int c = 0; c < 3; c++) begin
      cph[c] = 0;  cpl[c] = 0;  cboth[c] = 0;
    end
    csync = 0;
    sample(j);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      sample(j);
    end
  endtask

  initial begin
    int n_old, n_new;
    e0 = 0; ld0 = 0; per0 = 0; d0 = 0;
    e1 = 0; ld1 = 0; per1 = 0; d1 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ph1", ph1, 0);
    check("rst_pl1", pl1, 0);
    check("rst_sync0", sync0, 0);
    rst = 0;
    tick();

    // steady waveforms: DEAD=0 14/16 and DEAD=2 5/10
    per0 = 15; d0 = 14; ld0 = 1; e0 = 1;
    per1 = 9;  d1 = 12'h555; ld1 = 1; e1 = 1;
    tick();
    ld0 = 0; ld1 = 0;
    repeat (20) tick();
    wait_sync(0);
    measure(0, 16);
    check("d14_ph", cph[0], 14);
    check("d14_pl", cpl[0], 2);
    check("d14_sync", csync, 1);
    wait_sync(1);
    measure(1, 10);
    check("dt_ph", cph[0], 3);
    check("dt_pl", cpl[0], 3);
    check("dt_both_low", cboth[0], 4);
    check("dt_sync", csync, 1);

    // mid-period reload takes effect only at the next period start
    tick();
    d0 = 6; ld0 = 1;
    tick();
    ld0 = 0;
    repeat (40) tick();
    wait_sync(0);
    n_old = ph0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (k == 3) begin
        d0 = 2; ld0 = 1;
      end else begin
        ld0 = 0;
      end
      @(negedge clk);
      n_old += ph0;
    end
    check("reload_old_ph", n_old, 6);
    tick();
    @(negedge clk);
    check("reload_sync", sync0, 1);
    n_new = ph0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      n_new += ph0;
    end
    check("reload_new_ph", n_new, 2);

    // three independent channels 3/8/12 at PERIOD=15
    tick();
    per1 = 15; d1 = 12'hC83; ld1 = 1;
    tick();
    ld1 = 0;
    repeat (40) tick();
    wait_sync(1);
    measure(1, 16);
    check("ch0_ph", cph[0], 1);
    check("ch1_ph", cph[1], 6);
    check("ch2_ph", cph[2], 10);
    check("ch0_pl", cpl[0], 11);
    check("ch1_pl", cpl[1], 6);
    check("ch2_pl", cpl[2], 2);
    check("ch_sync", csync, 1);

    // boundaries: duty 0, PERIOD+1, all-ones; then PERIOD=0
    tick();
    per1 = 9; d1 = 12'hFA0; ld1 = 1;
    tick();
    ld1 = 0;
    repeat (30) tick();
    wait_sync(1);
    measure(1, 10);
    check("d0_ph", cph[0], 0);
    check("d0_pl", cpl[0], 10);
    check("dp1_pl", cpl[1], 0);
    check("dp1_ph", cph[1], 10);
    check("dff_pl", cpl[2], 0);
    tick();
    per1 = 0; ld1 = 1;
    tick();
    ld1 = 0;
    repeat (15) tick();
    wait_sync(1);
    measure(1, 8);
    check("p0_sync", csync, 8);

    // asynchronous reset mid-period, then enable gap
    tick();
    per1 = 9; d1 = 12'h555; ld1 = 1;
    tick();
    ld1 = 0;
    repeat (23) tick();
    rst = 1;
    #1;
    check("arst_ph1", ph1, 0);
    check("arst_pl1", pl1, 0);
    check("arst_sync1", sync1, 0);
    check("arst_pl0", pl0, 0);
    tick();
    rst = 0;
    repeat (20) tick();
    per1 = 9; d1 = 12'h555; ld1 = 1;
    tick();
    ld1 = 0;
    repeat (26) tick();
    e1 = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 4) e1 = 1;
      @(negedge clk);
      check("off_ph", ph1, 0);
      check("off_pl", pl1, 0);
      check("off_sync", sync1, 0);
    end
    tick();
    @(negedge clk);
    check("restart_sync", sync1, 1);
    check("restart_pl", pl1, 0);
    repeat (30) tick();
    wait_sync(1);
    measure(1, 10);
    check("again_ph", cph[0], 3);
    check("again_pl", cpl[0], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
